// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults, TX state encoding and parity helper
// used by both the transmitter and the receiver.
package uart_pkg;

    localparam int DATA_LENGTH_DEF = 8;
    localparam bit PARITY_DEF      = 1'b0;
    localparam int STOP_BITS_DEF   = 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        PARITY,
        STOP
    } tx_states_t;

    // Callers zero-extend narrower words; the extra zeros do not change the XOR.
    function automatic logic parity_calc(input logic [8:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// TX FIFO, prescaler and serial-line signals of the UART transmitter.
interface uart_tx_if import uart_pkg::*; #(
    parameter int DataLength = DATA_LENGTH_DEF
);
    logic [DataLength-1:0] i_fifo_data;
    logic                  i_fifo_empty;
    logic                  o_fifo_read_en;
    logic                  i_strobe;
    logic                  o_prescaler_en;
    logic                  o_tx;
    logic                  o_busy;

    modport slave (
        input  i_fifo_data, i_fifo_empty, i_strobe,
        output o_fifo_read_en, o_prescaler_en, o_tx, o_busy
    );

    modport master (
        output i_fifo_data, i_fifo_empty, i_strobe,
        input  o_fifo_read_en, o_prescaler_en, o_tx, o_busy
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmit engine: pops a show-ahead FIFO and serialises start, data (LSB
// first), optional parity and stop bits, one bit per prescaler strobe.
module uart_tx import uart_pkg::*; #(
    parameter bit Parity     = PARITY_DEF,
    parameter bit ParityOdd  = 1'b0,
    parameter int StopBits   = STOP_BITS_DEF,
    parameter int DataLength = DATA_LENGTH_DEF
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    uart_tx_if.slave bus
);

    if (StopBits != 1 && StopBits != 2) begin : g_bad_stop_bits
        $error("uart_tx: StopBits must be 1 or 2");
    end
    if (DataLength < 5 || DataLength > 9) begin : g_bad_data_length
        $error("uart_tx: DataLength must be in 5..9");
    end

    localparam int CW = $clog2(DataLength);

    tx_states_t            state;
    logic [DataLength-1:0] shift;
    logic [CW-1:0]         bit_cnt;
    logic                  stop_cnt;
    logic                  par_bit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state              <= IDLE;
            shift              <= '0;
            bit_cnt            <= '0;
            stop_cnt           <= 1'b0;
            par_bit            <= 1'b0;
            bus.o_tx           <= 1'b1;
            bus.o_busy         <= 1'b0;
            bus.o_fifo_read_en <= 1'b0;
            bus.o_prescaler_en <= 1'b0;
        end else begin
            bus.o_fifo_read_en <= 1'b0;
            case (state)
                IDLE: if (!bus.i_fifo_empty) begin
                    bus.o_fifo_read_en <= 1'b1;
                    bus.o_busy         <= 1'b1;
                    shift              <= bus.i_fifo_data;
                    state              <= FETCH;
                end
                FETCH: begin
                    bit_cnt  <= CW'(DataLength - 1);
                    stop_cnt <= 1'(StopBits - 1);
                    par_bit  <= parity_calc(9'(shift), ParityOdd);
                    // The prescaler restarts on this rising edge, so START gets a full period.
                    bus.o_prescaler_en <= 1'b1;
                    state    <= START;
                end
                START: if (bus.i_strobe) state <= DATA;
                DATA: if (bus.i_strobe) begin
                    shift   <= shift >> 1;
                    bit_cnt <= bit_cnt - 1'b1;
                    if (bit_cnt == '0) state <= Parity ? PARITY : STOP;
                end
                PARITY: if (bus.i_strobe) state <= STOP;
                STOP: if (bus.i_strobe) begin
                    if (stop_cnt == 1'b0) begin
                        bus.o_prescaler_en <= 1'b0;
                        bus.o_busy         <= 1'b0;
                        state              <= IDLE;
                    end else begin
                        stop_cnt <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // Line follows last cycle's state/shift so it changes only on a clock edge.
            case (state)
                START:   bus.o_tx <= 1'b0;
                DATA:    bus.o_tx <= shift[0];
                PARITY:  bus.o_tx <= par_bit;
                default: bus.o_tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameterisations, each with a FIFO and prescaler model;
// a line decoder scores frames against a queue of expected bytes.
module tb_uart_tx;

    localparam int NI  = 4;
    localparam int OVS = 16;
    // inst0: no parity, 1 stop; inst1: no parity, 2 stop; inst2: even parity; inst3: odd parity
    localparam logic [NI-1:0] PAR = 4'b1100;
    localparam logic [NI-1:0] ODD = 4'b1000;
    localparam logic [NI-1:0] TWO = 4'b0010;

    typedef struct packed { logic [7:0] d; logic p; } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NI-1:0] stray = '0;
    logic [NI-1:0] tx_w, busy_w, ren_w, pen_w;
    logic [7:0] fq [NI][$];
    exp_t exp_q [NI][$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx_if #(.DataLength(8)) u_if ();
        logic [3:0] pcnt;

        uart_tx #(
            .Parity(PAR[g]), .ParityOdd(ODD[g]), .StopBits(TWO[g] ? 2 : 1), .DataLength(8)
        ) u_dut (
            .i_clk(clk), .i_rst_n(rst_n), .bus(u_if)
        );

        always @(posedge clk or negedge rst_n)
            if (!rst_n) pcnt <= '0;
            else if (!u_if.o_prescaler_en) pcnt <= '0;
            else pcnt <= pcnt + 1'b1;
        assign u_if.i_strobe = (u_if.o_prescaler_en && pcnt == 4'(OVS - 1)) || stray[g];

        always @(posedge clk) if (u_if.o_fifo_read_en && fq[g].size() != 0) void'(fq[g].pop_front());
        always @(negedge clk) begin
            u_if.i_fifo_empty <= (fq[g].size() == 0);
            u_if.i_fifo_data  <= (fq[g].size() != 0) ? fq[g][0] : 8'h00;
        end

        assign tx_w[g]   = u_if.o_tx;
        assign busy_w[g] = u_if.o_busy;
        assign ren_w[g]  = u_if.o_fifo_read_en;
        assign pen_w[g]  = u_if.o_prescaler_en;
    end

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Expected line r clocks after the FIFO word becomes visible (r = 1 is the pop edge).
    function automatic logic exp_line(input int r, input logic [7:0] b, input logic p, input bit par_en);
        if (r >= 3 && r <= 18) return 1'b0;
        if (r >= 19 && r < 19 + OVS * 8) return b[(r - 19) / OVS];
        if (par_en && r >= 147 && r < 163) return p;
        return 1'b1;
    endfunction

    task automatic run_frames(input int k, input logic [7:0] b [3], input logic [2:0] hp,
                              input int nb, input string name);
        int L, f, r, bad_tx, bad_busy, bad_ren, nren;
        logic e_tx, e_busy, e_ren;
        L = 2 + OVS * (1 + 8 + int'(PAR[k]) + (TWO[k] ? 2 : 1));
        @(posedge clk); #2;
        for (int i = 0; i < nb; i++) begin
            fq[k].push_back(b[i]);
            exp_q[k].push_back('{d: b[i], p: hp[i]});
        end
        @(negedge clk);
        bad_tx = 0; bad_busy = 0; bad_ren = 0; nren = 0;
        for (int n = 1; n <= nb * L + 8; n++) begin
            @(negedge clk);
            f = (n - 1) / L;
            r = n - f * L;
            if (f < nb) begin
                e_tx = exp_line(r, b[f], hp[f], PAR[k]);
                e_busy = (r < L);
                e_ren = (r == 1);
            end else begin
                e_tx = 1'b1; e_busy = 1'b0; e_ren = 1'b0;
            end
            if (tx_w[k] !== e_tx) bad_tx++;
            if (busy_w[k] !== e_busy) bad_busy++;
            if (ren_w[k] !== e_ren) bad_ren++;
            if (ren_w[k] === 1'b1) nren++;
        end
        check({name, "_line_bad_cycles"}, bad_tx, 0);
        check({name, "_busy_bad_cycles"}, bad_busy, 0);
        check({name, "_readen_bad_cycles"}, bad_ren, 0);
        check({name, "_readen_pulses"}, nren, nb);
    endtask

    // Scoreboard monitor: decodes each line mid-bit and compares with the expected queue.
    initial begin
        int b, last;
        bit dact [NI];
        int dcnt [NI];
        logic [7:0] dsh [NI];
        logic dpar [NI];
        bit dfe [NI];
        exp_t e;
        for (int k = 0; k < NI; k++) begin dact[k] = 0; dcnt[k] = 0; dsh[k] = '0; dpar[k] = 0; dfe[k] = 0; end
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                if (!rst_n) dact[k] = 0;
                else if (!dact[k]) begin
                    if (tx_w[k] === 1'b0) begin dact[k] = 1; dcnt[k] = 1; dfe[k] = 0; end
                end else begin
                    if (dcnt[k] % OVS == OVS / 2) begin
                        b = dcnt[k] / OVS;
                        last = 8 + int'(PAR[k]) + (TWO[k] ? 2 : 1);
                        if (b == 0) begin if (tx_w[k] !== 1'b0) dfe[k] = 1; end
                        else if (b <= 8) dsh[k] = {tx_w[k], dsh[k][7:1]};
                        else if (PAR[k] && b == 9) dpar[k] = tx_w[k];
                        else if (tx_w[k] !== 1'b1) dfe[k] = 1;
                        if (b == last) begin
                            dact[k] = 0;
                            if (exp_q[k].size() == 0) check($sformatf("sb%0d_unexpected_frame", k), 1, 0);
                            else begin
                                e = exp_q[k].pop_front();
                                check($sformatf("sb%0d_data", k), int'(dsh[k]), int'(e.d));
                                if (PAR[k]) check($sformatf("sb%0d_parity", k), int'(dpar[k]), int'(e.p));
                                check($sformatf("sb%0d_framing", k), int'(dfe[k]), 0);
                            end
                        end
                    end
                    dcnt[k]++;
                end
            end
        end
    end

    initial begin
        logic [7:0] bv [3];
        int bad;

        repeat (3) @(negedge clk);
        #1;
        check("reset_tx", int'(tx_w), 15);
        check("reset_busy", int'(busy_w), 0);
        check("reset_readen", int'(ren_w), 0);
        check("reset_prescaler_en", int'(pen_w), 0);
        @(negedge clk); rst_n = 1'b1;

        // Empty FIFO with stray strobes: nothing may move.
        bad = 0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            stray = (n % 100 == 50) ? '1 : '0;
            if (tx_w !== '1 || busy_w !== '0 || ren_w !== '0 || pen_w !== '0) bad++;
        end
        stray = '0;
        check("empty_fifo_bad_cycles", bad, 0);

        bv = '{8'h55, 8'h00, 8'h00};
        run_frames(0, bv, 3'b000, 1, "single_55");
        bv = '{8'h07, 8'h00, 8'h00};
        run_frames(2, bv, 3'b001, 1, "parity_even_07");
        run_frames(3, bv, 3'b000, 1, "parity_odd_07");
        bv = '{8'hA3, 8'h00, 8'h00};
        run_frames(1, bv, 3'b000, 1, "two_stop_A3");
        bv = '{8'h00, 8'hFF, 8'h3C};
        run_frames(0, bv, 3'b000, 3, "b2b");

        // Reset during data bit 3 of 0x81.
        @(posedge clk); #2;
        fq[0].push_back(8'h81);
        exp_q[0].push_back('{d: 8'h81, p: 1'b0});
        @(negedge clk);
        repeat (72) @(negedge clk);
        rst_n = 1'b0;
        exp_q[0].delete();
        #1;
        check("midreset_outputs", int'({tx_w[0], busy_w[0], ren_w[0], pen_w[0]}), 8);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || ren_w[0] !== 1'b0 || pen_w[0] !== 1'b0) bad++;
        end
        check("post_reset_idle_bad_cycles", bad, 0);
        bv = '{8'hC3, 8'h00, 8'h00};
        run_frames(0, bv, 3'b000, 1, "post_reset_C3");

        repeat (20) @(negedge clk);
        for (int k = 0; k < NI; k++) check($sformatf("sb%0d_leftover", k), exp_q[k].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
